// File: rtl/dscope_cmd_pkg.sv
// Shared definitions for the DSP parameter command bus: sync word, command
// field layout, NCMD codes and the issuer state encoding.
package dscope_cmd_pkg;

   localparam logic [31:0] MAGIC = 32'hF0AA550F;

   localparam int FLD_GLOBAL   = 31;
   localparam int FLD_CH_HI    = 30;
   localparam int FLD_CH_LO    = 29;
   localparam int FLD_SLOT_HI  = 28;
   localparam int FLD_SLOT_LO  = 27;
   localparam int FLD_NCMD_HI  = 26;
   localparam int FLD_NCMD_LO  = 23;

   typedef enum logic [3:0] {
      NCMD_PULSE_MASK  = 4'd1,
      NCMD_RX_INDEX    = 4'd2,
      NCMD_HIT_LEN     = 4'd3,
      NCMD_GND_LEN     = 4'd4,
      NCMD_HUSH_LEN    = 4'd5,
      NCMD_PULSE_COUNT = 4'd6,
      NCMD_DAC_LEVEL   = 4'd7,
      NCMD_ADC_RATIO   = 4'd8,
      NCMD_ADC_TICK    = 4'd9,
      NCMD_SLOT_TIME   = 4'd10,
      NCMD_ADC_DELAY   = 4'd11
   } ncmd_e;

   typedef struct packed {
      logic        global;
      logic [1:0]  ch;
      logic [1:0]  slot;
      logic [3:0]  ncmd;
      logic [22:0] data;
   } cmd_fields_t;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_CMD   = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

endpackage

// File: rtl/cmd_word_check.sv
// Combinational decode and validity check of a 32-bit parameter command word.
module cmd_word_check
   import dscope_cmd_pkg::*;
#(
   parameter bit CHECK_NCMD = 1'b1
) (
   input  logic [31:0] word,
   output cmd_fields_t fields,
   output logic        valid
);

   cmd_fields_t fields_s;
   logic        ncmd_in_range_s;

   assign fields_s = cmd_fields_t'(word);
   assign fields   = fields_s;

   // Global commands and unchecked builds bypass the NCMD range test.
   always_comb begin
      ncmd_in_range_s = (fields_s.ncmd >= 4'(NCMD_PULSE_MASK)) &&
                        (fields_s.ncmd <= 4'(NCMD_ADC_DELAY));
      valid = fields_s.global || !CHECK_NCMD || ncmd_in_range_s;
   end

endmodule

// File: rtl/cmd_frame_issuer.sv
// Host-side initiator of the parameter command bus: hunts the sync word in the
// host byte stream, assembles and validates a command, then issues it.
module cmd_frame_issuer
   import dscope_cmd_pkg::*;
#(
   parameter logic [31:0] MAGIC_WORD = MAGIC,
   parameter logic [15:0] TIMEOUT    = 16'd2000,
   parameter bit          CHECK_NCMD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_vld,
   output logic        o_byte_rdy,
   output logic [31:0] o_cmd_magic,
   output logic [31:0] o_cmd_command,
   output logic        o_cmd_vld,
   input  logic        i_cmd_rdy,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_err_cnt,
   output logic        o_busy
);

   state_e      state_r, state_s;
   logic [31:0] sr_r, sr_s;
   logic [1:0]  byte_cnt_r, byte_cnt_s;
   logic [15:0] gap_cnt_r, gap_cnt_s;
   logic [31:0] cmd_r, cmd_s;
   logic [15:0] frame_cnt_r, frame_cnt_s;
   logic [15:0] err_cnt_r, err_cnt_s;
   logic        vld_r, vld_s;
   logic [31:0] magic_r, magic_s;
   logic        busy_r, busy_s;
   logic        byte_rdy_r, byte_rdy_s;
   logic        byte_acc_s;
   logic [31:0] sr_shift_s;
   cmd_fields_t chk_fields_s;
   logic        chk_valid_s;

   assign byte_acc_s = i_byte_vld && byte_rdy_r;
   assign sr_shift_s = {sr_r[23:0], i_byte};

   cmd_word_check #(.CHECK_NCMD(CHECK_NCMD)) u_check (
      .word   ({cmd_r[23:0], i_byte}),
      .fields (chk_fields_s),
      .valid  (chk_valid_s)
   );

   // Next-state and next-output logic for hunt, assemble and issue phases.
   always_comb begin
      state_s     = state_r;
      sr_s        = sr_r;
      byte_cnt_s  = byte_cnt_r;
      gap_cnt_s   = gap_cnt_r;
      cmd_s       = cmd_r;
      frame_cnt_s = frame_cnt_r;
      err_cnt_s   = err_cnt_r;
      vld_s       = vld_r;
      magic_s     = magic_r;
      case (state_r)
         ST_HUNT: begin
            if (byte_acc_s) begin
               sr_s = sr_shift_s;
               if (sr_shift_s == MAGIC_WORD) begin
                  state_s    = ST_CMD;
                  byte_cnt_s = 2'd0;
                  gap_cnt_s  = 16'd0;
               end else begin
                  state_s = ST_HUNT;
               end
            end else begin
               state_s = ST_HUNT;
            end
         end
         ST_CMD: begin
            if (byte_acc_s) begin
               cmd_s     = chk_fields_s;
               gap_cnt_s = 16'd0;
               if (byte_cnt_r == 2'd3) begin
                  if (chk_valid_s) begin
                     state_s = ST_ISSUE;
                     vld_s   = 1'b1;
                     magic_s = MAGIC_WORD;
                  end else begin
                     state_s   = ST_HUNT;
                     sr_s      = 32'd0;
                     err_cnt_s = sat_inc16(err_cnt_r);
                  end
               end else begin
                  byte_cnt_s = byte_cnt_r + 2'd1;
               end
            // This idle cycle is the TIMEOUT-th since the last accepted byte.
            end else if (gap_cnt_r >= (TIMEOUT - 16'd1)) begin
               state_s   = ST_HUNT;
               sr_s      = 32'd0;
               err_cnt_s = sat_inc16(err_cnt_r);
            end else begin
               gap_cnt_s = gap_cnt_r + 16'd1;
            end
         end
         ST_ISSUE: begin
            if (vld_r && i_cmd_rdy) begin
               state_s     = ST_HUNT;
               sr_s        = 32'd0;
               vld_s       = 1'b0;
               magic_s     = 32'd0;
               frame_cnt_s = sat_inc16(frame_cnt_r);
            end else begin
               state_s = ST_ISSUE;
            end
         end
         default: begin
            state_s = ST_HUNT;
            sr_s    = 32'd0;
            vld_s   = 1'b0;
            magic_s = 32'd0;
         end
      endcase
      busy_s     = (state_s != ST_HUNT);
      byte_rdy_s = (state_s != ST_ISSUE);
   end

   // State and output registers; reset discards any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_HUNT;
         sr_r        <= 32'd0;
         byte_cnt_r  <= 2'd0;
         gap_cnt_r   <= 16'd0;
         cmd_r       <= 32'd0;
         frame_cnt_r <= 16'd0;
         err_cnt_r   <= 16'd0;
         vld_r       <= 1'b0;
         magic_r     <= 32'd0;
         busy_r      <= 1'b0;
         byte_rdy_r  <= 1'b1;
      end else begin
         state_r     <= state_s;
         sr_r        <= sr_s;
         byte_cnt_r  <= byte_cnt_s;
         gap_cnt_r   <= gap_cnt_s;
         cmd_r       <= cmd_s;
         frame_cnt_r <= frame_cnt_s;
         err_cnt_r   <= err_cnt_s;
         vld_r       <= vld_s;
         magic_r     <= magic_s;
         busy_r      <= busy_s;
         byte_rdy_r  <= byte_rdy_s;
      end
   end

   assign o_byte_rdy    = byte_rdy_r;
   assign o_cmd_magic   = magic_r;
   assign o_cmd_command = cmd_r;
   assign o_cmd_vld     = vld_r;
   assign o_frame_cnt   = frame_cnt_r;
   assign o_err_cnt     = err_cnt_r;
   assign o_busy        = busy_r;

endmodule

// File: tb/tb_cmd_frame_issuer.sv
// Directed bench for cmd_frame_issuer with a queue scoreboard of expected commands.
module tb_cmd_frame_issuer;

   localparam logic [31:0] SYNC = 32'hF0AA550F;
   localparam int          TMO  = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_byte;
   logic        i_byte_vld;
   logic        o_byte_rdy;
   logic [31:0] o_cmd_magic;
   logic [31:0] o_cmd_command;
   logic        o_cmd_vld;
   logic        i_cmd_rdy;
   logic [15:0] o_frame_cnt;
   logic [15:0] o_err_cnt;
   logic        o_busy;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   cmd_frame_issuer dut (
      .clk           (clk),
      .rst           (rst),
      .i_byte        (i_byte),
      .i_byte_vld    (i_byte_vld),
      .o_byte_rdy    (o_byte_rdy),
      .o_cmd_magic   (o_cmd_magic),
      .o_cmd_command (o_cmd_command),
      .o_cmd_vld     (o_cmd_vld),
      .i_cmd_rdy     (i_cmd_rdy),
      .o_frame_cnt   (o_frame_cnt),
      .o_err_cnt     (o_err_cnt),
      .o_busy        (o_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_byte     = b;
      i_byte_vld = 1'b1;
      tick();
      i_byte_vld = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic send_frame(input logic [31:0] cmd);
      send_word(SYNC);
      send_word(cmd);
   endtask

   // Scoreboard: every handshake must match the oldest expected command.
   always @(negedge clk) begin
      logic [31:0] exp_cmd;
      if (!rst && o_cmd_vld && i_cmd_rdy) begin
         exp_cmd = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
         check("issue_cmd", o_cmd_command, exp_cmd);
         check("issue_magic", o_cmd_magic, SYNC);
      end
   end

   initial begin
      rst        = 1'b1;
      i_byte     = 8'h00;
      i_byte_vld = 1'b0;
      i_cmd_rdy  = 1'b1;
      #1;
      check("rst_vld", {31'd0, o_cmd_vld}, 32'd0);
      check("rst_magic", o_cmd_magic, 32'd0);
      check("rst_cmd", o_cmd_command, 32'd0);
      check("rst_frame", {16'd0, o_frame_cnt}, 32'd0);
      check("rst_err", {16'd0, o_err_cnt}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_byte_rdy", {31'd0, o_byte_rdy}, 32'd1);
      #12 rst = 1'b0;
      tick();

      // 1: basic frame with immediate handshake
      sb.push_back(32'h31800014);
      send_frame(32'h31800014);
      check("t1_vld", {31'd0, o_cmd_vld}, 32'd1);
      check("t1_cmd", o_cmd_command, 32'h31800014);
      check("t1_magic", o_cmd_magic, SYNC);
      check("t1_byte_rdy", {31'd0, o_byte_rdy}, 32'd0);
      tick();
      check("t1_frame", {16'd0, o_frame_cnt}, 32'd1);
      check("t1_vld_drop", {31'd0, o_cmd_vld}, 32'd0);
      check("t1_magic_drop", o_cmd_magic, 32'd0);
      check("t1_busy", {31'd0, o_busy}, 32'd0);

      // 2: resync over a false start
      sb.push_back(32'h31800014);
      send_byte(8'h00);
      send_byte(8'hF0);
      send_frame(32'h31800014);
      check("t2_vld", {31'd0, o_cmd_vld}, 32'd1);
      tick();
      check("t2_frame", {16'd0, o_frame_cnt}, 32'd2);
      check("t2_err", {16'd0, o_err_cnt}, 32'd0);

      // 3: backpressure holds the command for six cycles
      i_cmd_rdy = 1'b0;
      sb.push_back(32'h31800014);
      send_frame(32'h31800014);
      for (int i = 0; i < 6; i++) begin
         check("t3_vld_hold", {31'd0, o_cmd_vld}, 32'd1);
         check("t3_cmd_hold", o_cmd_command, 32'h31800014);
         check("t3_magic_hold", o_cmd_magic, SYNC);
         check("t3_byte_rdy", {31'd0, o_byte_rdy}, 32'd0);
         check("t3_frame_hold", {16'd0, o_frame_cnt}, 32'd2);
         if (i == 5) i_cmd_rdy = 1'b1;
         tick();
      end
      check("t3_frame", {16'd0, o_frame_cnt}, 32'd3);
      check("t3_vld_drop", {31'd0, o_cmd_vld}, 32'd0);

      // 4: non-global ncmd=0 rejected, global accepted
      send_frame(32'h00000000);
      check("t4_no_vld", {31'd0, o_cmd_vld}, 32'd0);
      check("t4_err", {16'd0, o_err_cnt}, 32'd1);
      check("t4_busy", {31'd0, o_busy}, 32'd0);
      sb.push_back(32'h80640009);
      send_frame(32'h80640009);
      check("t4_glob_vld", {31'd0, o_cmd_vld}, 32'd1);
      check("t4_glob_cmd", o_cmd_command, 32'h80640009);
      tick();
      check("t4_frame", {16'd0, o_frame_cnt}, 32'd4);

      // 5: inter-byte timeout, then the just-in-time contrast
      send_word(SYNC);
      send_byte(8'h31);
      send_byte(8'h80);
      repeat (TMO - 1) tick();
      check("t5_busy_pre", {31'd0, o_busy}, 32'd1);
      tick();
      check("t5_busy_drop", {31'd0, o_busy}, 32'd0);
      check("t5_err", {16'd0, o_err_cnt}, 32'd2);
      sb.push_back(32'h31800014);
      send_word(SYNC);
      send_byte(8'h31);
      send_byte(8'h80);
      repeat (TMO - 1) tick();
      send_byte(8'h00);
      send_byte(8'h14);
      check("t5_late_vld", {31'd0, o_cmd_vld}, 32'd1);
      check("t5_late_cmd", o_cmd_command, 32'h31800014);
      tick();
      check("t5_late_frame", {16'd0, o_frame_cnt}, 32'd5);
      sb.push_back(32'h2A000123);
      send_frame(32'h2A000123);
      check("t5_next_cmd", o_cmd_command, 32'h2A000123);
      tick();
      check("t5_next_frame", {16'd0, o_frame_cnt}, 32'd6);
      check("t5_err_final", {16'd0, o_err_cnt}, 32'd2);

      // 6: asynchronous reset during issue
      i_cmd_rdy = 1'b0;
      send_frame(32'h31800014);
      check("t6_vld_pre", {31'd0, o_cmd_vld}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_vld_rst", {31'd0, o_cmd_vld}, 32'd0);
      check("t6_magic_rst", o_cmd_magic, 32'd0);
      check("t6_frame_rst", {16'd0, o_frame_cnt}, 32'd0);
      check("t6_err_rst", {16'd0, o_err_cnt}, 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      i_cmd_rdy = 1'b1;
      tick();
      sb.push_back(32'h31800014);
      send_frame(32'h31800014);
      check("t6_post_vld", {31'd0, o_cmd_vld}, 32'd1);
      tick();
      check("t6_post_frame", {16'd0, o_frame_cnt}, 32'd1);
      tick();
      check("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
